// File: rtl/dac_control.sv
`default_nettype none
// ============================================================================
// Module   : dac_control
// Purpose  : Register-bus front end and serialiser for an 8-channel, 12-bit
//            serial DAC. Per-channel values written over the EBI bus are
//            queued in a pending mask and sent round-robin as 16-bit SPI
//            frames {0, ch[2:0], value[11:0]}, MSB first. The DAC samples
//            dac_din on the falling edge of dac_sclk.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            addr/data_in      - [15:8] controller id, [7:0] register; data
//            enable/re/wr      - bus select, read strobe, write strobe
//            data_out          - registered read data (0 when no read)
//            busy              - FSM active or any channel pending
//            current_time      - global time base for the launch gate
//            dac_sclk/sync_n/din/ldac_n - serial DAC interface
// Options  : DAC_LDAC_EN - when defined, dac_ldac_n pulses low for CLK_DIV
//            cycles after the last frame of a burst; otherwise dac_ldac_n is
//            tied low and the DAC updates at every sync rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module dac_control #(
  parameter logic [7:0] CTRL_ID      = 8'h02,
  parameter int         NUM_CHANNELS = 8,
  parameter int         CLK_DIV      = 4,
  parameter int         GAP_CYCLES   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [31:0] data_in,
  input  logic        enable,
  input  logic        re,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        busy,
  input  logic [31:0] current_time,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        dac_ldac_n
);

  // One shared phase counter; it must hold 2*CLK_DIV-1 and GAP_CYCLES-1.
  localparam int CNT_SPAN = (2 * CLK_DIV > GAP_CYCLES) ? 2 * CLK_DIV : GAP_CYCLES;
  localparam int CW       = (CNT_SPAN < 2) ? 1 : $clog2(CNT_SPAN);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [7:0] REG_VALUE  = 8'h01;
  localparam logic [7:0] REG_ID     = 8'h09;
  localparam logic [7:0] REG_STATUS = 8'h0A;
  localparam logic [7:0] REG_LAST   = 8'h0B;
  localparam logic [7:0] REG_START  = 8'h0C;

`ifdef DAC_LDAC_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_LDAC  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   last_word_q, last_word_d;
  logic [11:0]   value_q [NUM_CHANNELS];
  logic [11:0]   value_d [NUM_CHANNELS];
  logic [7:0]    pending_q, pending_d;
  logic [31:0]   start_time_q, start_time_d;
  logic [2:0]    next_ch_q, next_ch_d;
  logic [15:0]   data_out_q, data_out_d;
  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          sync_n_q, sync_n_d;
  logic          din_q, din_d;
`ifdef DAC_LDAC_EN
  logic          ldac_n_q, ldac_n_d;
`endif

  logic          access;
  logic [2:0]    wr_ch;
  logic          wr_value;
  logic          wr_start;
  logic          go;
  logic          sel_found;
  logic [2:0]    sel_ch;
  logic [2:0]    scan_ch;
  logic [15:0]   load_word;

  assign access   = enable & (addr[15:8] == CTRL_ID);
  assign wr_ch    = data_in[18:16];
  assign wr_value = access & wr & (addr[7:0] == REG_VALUE) & (32'(wr_ch) < 32'(NUM_CHANNELS));
  assign wr_start = access & wr & (addr[7:0] == REG_START);
  assign go       = (|pending_q) & ((start_time_q == 32'd0) | (current_time >= start_time_q));

  // Round-robin pick: scan starts at the channel after the last one sent.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = 3'd0;
    scan_ch   = 3'd0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      scan_ch = 3'((int'(next_ch_q) + i) % NUM_CHANNELS);
      if (!sel_found && pending_q[scan_ch]) begin
        sel_found = 1'b1;
        sel_ch    = scan_ch;
      end
    end
  end

  assign load_word = {1'b0, sel_ch, value_q[sel_ch]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    last_word_d  = last_word_q;
    value_d      = value_q;
    pending_d    = pending_q;
    start_time_d = start_time_q;
    next_ch_d    = next_ch_q;
    sclk_d       = sclk_q;
    sync_n_d     = sync_n_q;
    din_d        = din_q;
`ifdef DAC_LDAC_EN
    ldac_n_d     = ldac_n_q;
`endif
    data_out_d   = 16'd0;

    if (access & re) begin
      case (addr[7:0])
        REG_ID:     data_out_d = 16'h0DAC;
        REG_STATUS: data_out_d = {7'd0, busy_q, pending_q};
        REG_LAST:   data_out_d = last_word_q;
        default:    data_out_d = 16'd0;
      endcase
    end

    if (wr_start) start_time_d = data_in;
    if (wr_value) value_d[wr_ch] = data_in[11:0];

    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (sel_found) begin
          pending_d[sel_ch] = 1'b0;
          shift_d           = load_word;
          last_word_d       = load_word;
          next_ch_d         = 3'((int'(sel_ch) + 1) % NUM_CHANNELS);
          din_d             = load_word[15];
          sclk_d            = 1'b1;
          sync_n_d          = 1'b0;
          cnt_d             = '0;
          bit_d             = 4'd0;
          state_d           = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) sclk_d = 1'b0;
        if (cnt_q == BIT_LAST) begin
          cnt_d  = '0;
          sclk_d = 1'b1;
          if (bit_q == 4'd15) begin
            sync_n_d = 1'b1;
            din_d    = 1'b0;
            state_d  = ST_GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            din_d   = shift_q[14];
            shift_d = {shift_q[14:0], 1'b0};
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
`ifdef DAC_LDAC_EN
          // Only the end of a burst (nothing left queued) gets the load pulse.
          if (pending_q == 8'd0) begin
            state_d  = ST_LDAC;
            ldac_n_d = 1'b0;
          end
`endif
        end
      end
`ifdef DAC_LDAC_EN
      ST_LDAC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) begin
          cnt_d    = '0;
          ldac_n_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Applied after the LOAD clear so a same-cycle rewrite keeps the channel armed.
    if (wr_value) pending_d[wr_ch] = 1'b1;

    busy_d = (state_d != ST_IDLE) | (|pending_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= 4'd0;
      shift_q      <= 16'd0;
      last_word_q  <= 16'd0;
      for (int i = 0; i < NUM_CHANNELS; i++) value_q[i] <= 12'd0;
      pending_q    <= 8'd0;
      start_time_q <= 32'd0;
      next_ch_q    <= 3'd0;
      data_out_q   <= 16'd0;
      busy_q       <= 1'b0;
      sclk_q       <= 1'b1;
      sync_n_q     <= 1'b1;
      din_q        <= 1'b0;
`ifdef DAC_LDAC_EN
      ldac_n_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      last_word_q  <= last_word_d;
      value_q      <= value_d;
      pending_q    <= pending_d;
      start_time_q <= start_time_d;
      next_ch_q    <= next_ch_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      sclk_q       <= sclk_d;
      sync_n_q     <= sync_n_d;
      din_q        <= din_d;
`ifdef DAC_LDAC_EN
      ldac_n_q     <= ldac_n_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_n_q;
  assign dac_din    = din_q;
`ifdef DAC_LDAC_EN
  assign dac_ldac_n = ldac_n_q;
`else
  assign dac_ldac_n = 1'b0;
`endif

endmodule
`default_nettype wire
